// File: rtl/vga_win_pkg.sv
// Shared types and constants for the VGA image-window controller.
package vga_win_pkg;

    localparam int COORD_W = 11;
    localparam int RGB_W   = 24;

    localparam logic [RGB_W-1:0] BG_DEFAULT     = 24'h000000;
    localparam logic [RGB_W-1:0] BORDER_DEFAULT = 24'hFFFFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_UPD_X = 2'd1,
        S_UPD_Y = 2'd2
    } mot_state_t;

    // One extra bit of headroom so lo+len never wraps.
    function automatic logic in_span(input logic [COORD_W:0] v,
                                     input logic [COORD_W:0] lo,
                                     input logic [COORD_W:0] len);
        return (v >= lo) && (v < lo + len);
    endfunction

endpackage

// File: rtl/vga_win_bounce.sv
// Single-axis window position updater: steps by STEP per update and bounces
// off 0 and DISP-IMG, reversing direction at each edge.
module vga_win_bounce
    import vga_win_pkg::*;
#(
    parameter logic [COORD_W-1:0] DISP = 11'd1280,
    parameter logic [COORD_W-1:0] IMG  = 11'd128,
    parameter logic [COORD_W-1:0] STEP = 11'd2,
    parameter logic [COORD_W-1:0] INIT = 11'd0
) (
    input  logic               vga_clk,
    input  logic               sys_rst_n,
    input  logic               upd,
    output logic [COORD_W-1:0] pos,
    output logic               dir
);

    localparam logic [COORD_W:0] POS_MAX = {1'b0, DISP} - {1'b0, IMG};

    logic [COORD_W:0] fwd;

    assign fwd = {1'b0, pos} + {1'b0, STEP};

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pos <= INIT;
            dir <= 1'b1;
        end else if (upd) begin
            if (dir) begin
                if (fwd >= POS_MAX) begin
                    pos <= POS_MAX[COORD_W-1:0];
                    dir <= 1'b0;
                end else begin
                    pos <= fwd[COORD_W-1:0];
                end
            end else if (pos <= STEP) begin
                pos <= '0;
                dir <= 1'b1;
            end else begin
                pos <= pos - STEP;
            end
        end
    end

endmodule

// File: rtl/vga_win_ctrl.sv
// Pixel source placing an IMG_W x IMG_H ROM image window on the display.
// Optional macro VGA_WIN_BORDER_EN paints the window perimeter BORDER_COLOR.
module vga_win_ctrl
    import vga_win_pkg::*;
#(
    parameter logic [COORD_W-1:0] H_DISP       = 11'd1280,
    parameter logic [COORD_W-1:0] V_DISP       = 11'd1024,
    parameter logic [COORD_W-1:0] IMG_W        = 11'd128,
    parameter logic [COORD_W-1:0] IMG_H        = 11'd128,
    parameter int                 ADDR_W       = 14,
    parameter logic [COORD_W-1:0] STEP         = 11'd2,
    parameter logic [COORD_W-1:0] INIT_X       = 11'd0,
    parameter logic [COORD_W-1:0] INIT_Y       = 11'd0,
    parameter logic [RGB_W-1:0]   BG_COLOR     = BG_DEFAULT,
    parameter logic [RGB_W-1:0]   BORDER_COLOR = BORDER_DEFAULT
) (
    input  logic               vga_clk,
    input  logic               sys_rst_n,
    input  logic               vga_vs,
    input  logic [COORD_W-1:0] pixel_xpos,
    input  logic [COORD_W-1:0] pixel_ypos,
    input  logic               move_en,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic               rom_rden,
    input  logic [RGB_W-1:0]   rom_q,
    output logic [RGB_W-1:0]   pixel_data,
    output logic [COORD_W-1:0] win_x,
    output logic [COORD_W-1:0] win_y
);

    localparam int               PIX_CNT   = int'(IMG_W) * int'(IMG_H);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(PIX_CNT - 1);

    logic             vs_d;
    logic             frame_start;
    logic             req;
    logic             hit;
    logic             hit_d;
    logic             edge_d;
    logic [COORD_W:0] col;
    logic [COORD_W:0] row;
    logic [ADDR_W-1:0] addr_cnt;
    mot_state_t       state;
    logic             upd_x;
    logic             upd_y;
    logic             dir_x;
    logic             dir_y;

    // Request qualification and window hit (12-bit compares).
    assign req = (pixel_ypos != '0);
    assign col = {1'b0, pixel_xpos};
    assign row = {1'b0, pixel_ypos} - 12'd1;
    assign hit = req
              && in_span(col, {1'b0, win_x}, {1'b0, IMG_W})
              && in_span(row, {1'b0, win_y}, {1'b0, IMG_H});

    assign frame_start = vs_d & ~vga_vs;
    assign rom_rden    = hit;
    assign rom_addr    = addr_cnt;

    // Raster order makes a plain counter equal the window-relative address.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vs_d     <= 1'b1;
            hit_d    <= 1'b0;
            addr_cnt <= '0;
        end else begin
            vs_d  <= vga_vs;
            hit_d <= hit;
            if (frame_start)
                addr_cnt <= '0;
            else if (hit)
                addr_cnt <= (addr_cnt == ADDR_LAST) ? '0 : addr_cnt + 1'b1;
        end
    end

`ifdef VGA_WIN_BORDER_EN
    logic on_edge;

    assign on_edge = (col == {1'b0, win_x})
                  || (col == {1'b0, win_x} + {1'b0, IMG_W} - 12'd1)
                  || (row == {1'b0, win_y})
                  || (row == {1'b0, win_y} + {1'b0, IMG_H} - 12'd1);

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            edge_d <= 1'b0;
        else
            edge_d <= hit && on_edge;
    end
`else
    assign edge_d = 1'b0;
`endif

    always_comb begin
        pixel_data = BG_COLOR;
        if (hit_d)
            pixel_data = edge_d ? BORDER_COLOR : rom_q;
    end

    // Motion sequencer: one axis per cycle right after the vsync falling edge.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= S_IDLE;
            upd_x <= 1'b0;
            upd_y <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    upd_x <= 1'b0;
                    upd_y <= 1'b0;
                    if (frame_start && move_en) begin
                        state <= S_UPD_X;
                        upd_x <= 1'b1;
                    end
                end
                S_UPD_X: begin
                    state <= S_UPD_Y;
                    upd_x <= 1'b0;
                    upd_y <= 1'b1;
                end
                S_UPD_Y: begin
                    state <= S_IDLE;
                    upd_x <= 1'b0;
                    upd_y <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    upd_x <= 1'b0;
                    upd_y <= 1'b0;
                end
            endcase
        end
    end

    vga_win_bounce #(
        .DISP (H_DISP),
        .IMG  (IMG_W),
        .STEP (STEP),
        .INIT (INIT_X)
    ) u_bounce_x (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .upd       (upd_x),
        .pos       (win_x),
        .dir       (dir_x)
    );

    vga_win_bounce #(
        .DISP (V_DISP),
        .IMG  (IMG_H),
        .STEP (STEP),
        .INIT (INIT_Y)
    ) u_bounce_y (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .upd       (upd_y),
        .pos       (win_y),
        .dir       (dir_y)
    );

    // Direction is internal state; keep it visible for debug probes.
    logic dbg_dir_unused;
    assign dbg_dir_unused = dir_x ^ dir_y;

endmodule
